// File: rtl/sysid_checker.sv
// Boot-time image check: reads the system-ID word (address 0) and the timestamp
// word (address 1) over Avalon-MM and compares both against build-time constants.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1328238288,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RD_ID;
            stall_cnt   <= '0;
            avm_address <= 1'b0;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        RD_ID, RD_TS: begin
          if (avm_waitrequest) begin
            // The stall that would make TIMEOUT_CYCLES in a row aborts; the
            // counter parks at the limit instead of wrapping.
            if (stall_cnt >= TO_LAST) begin
              state     <= DONE;
              stall_cnt <= TO_MAX;
              avm_read  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              timeout   <= 1'b1;
              id_ok     <= 1'b0;
              ts_ok     <= 1'b0;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end else if (state == RD_ID) begin
            id_value  <= avm_readdata;
            id_ok     <= (avm_readdata == EXPECTED_ID);
            stall_cnt <= '0;
            if (CHECK_TS) begin
              // avm_read stays high; the timestamp request starts next cycle.
              state       <= RD_TS;
              avm_address <= 1'b1;
            end else begin
              state    <= DONE;
              ts_ok    <= 1'b1;
              avm_read <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            ts_value  <= avm_readdata;
            ts_ok     <= (avm_readdata == EXPECTED_TS);
            stall_cnt <= '0;
            state     <= DONE;
            avm_read  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboarded bench: two checkers (timestamp checked / skipped) share one
// scripted slave; a negedge monitor compares reads and results against queues.
module tb_sysid_checker;

  localparam logic [31:0] TS = 32'd1328238288;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    int          stalls;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel   = 1'b0;
  always #5 clock = ~clock;

  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  logic        a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_timeout;
  logic [31:0] a_id_value, a_ts_value;
  logic        b_addr, b_read, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
  logic [31:0] b_id_value, b_ts_value;

  sysid_checker #(.CHECK_TS(1'b1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .timeout(a_timeout), .id_value(a_id_value), .ts_value(a_ts_value)
  );

  sysid_checker #(.CHECK_TS(1'b0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .timeout(b_timeout), .id_value(b_id_value), .ts_value(b_ts_value)
  );

  logic        m_addr, m_read, m_busy, m_done, m_id_ok, m_ts_ok, m_timeout;
  logic [31:0] m_id_value, m_ts_value;
  assign m_addr     = sel ? b_addr     : a_addr;
  assign m_read     = sel ? b_read     : a_read;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;
  assign m_id_ok    = sel ? b_id_ok    : a_id_ok;
  assign m_ts_ok    = sel ? b_ts_ok    : a_ts_ok;
  assign m_timeout  = sel ? b_timeout  : a_timeout;
  assign m_id_value = sel ? b_id_value : a_id_value;
  assign m_ts_value = sel ? b_ts_value : a_ts_value;

  // Scripted slave: stalls each read for a configured number of cycles.
  int          stall_id_cfg = 0;
  int          stall_ts_cfg = 0;
  bit          stuck = 1'b0;
  logic [31:0] id_data = '0;
  logic [31:0] ts_data = '0;
  int          scnt;

  assign avm_waitrequest = stuck || (m_read && (scnt < (m_addr ? stall_ts_cfg : stall_id_cfg)));
  assign avm_readdata    = m_addr ? ts_data : id_data;

  always @(posedge clock or posedge reset) begin
    if (reset)                            scnt <= 0;
    else if (!m_read || !avm_waitrequest) scnt <= 0;
    else                                  scnt <= scnt + 1;
  end

  int   checks = 0;
  int   errors = 0;
  res_t res_q[$];
  logic addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  int   stalls = 0;
  logic prev_stall = 1'b0, prev_addr = 1'b0, prev_done = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      stalls = 0; prev_stall = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_stall && !m_timeout) begin
        chk("hold_read", 32'(m_read), 32'd1);
        chk("hold_addr", 32'(m_addr), 32'(prev_addr));
      end
      if (m_read && avm_waitrequest) stalls++;
      if (m_read && !avm_waitrequest) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_read: got read at addr %0d expected none", m_addr);
        end else begin
          chk("rd_addr", 32'(m_addr), 32'(addr_q.pop_front()));
        end
      end
      if (m_done && !prev_done) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_done: got done expected none");
        end else begin
          res_t e;
          e = res_q.pop_front();
          chk("id_ok",    32'(m_id_ok),   32'(e.id_ok));
          chk("ts_ok",    32'(m_ts_ok),   32'(e.ts_ok));
          chk("timeout",  32'(m_timeout), 32'(e.timeout));
          chk("id_value", m_id_value,     e.id_value);
          chk("ts_value", m_ts_value,     e.ts_value);
          chk("stalls",   32'(stalls),    32'(e.stalls));
          chk("busy_off", 32'(m_busy),    32'd0);
        end
        stalls = 0;
      end
      prev_stall = m_read && avm_waitrequest;
      prev_addr  = m_addr;
      prev_done  = m_done;
    end
  end

  // One check run; exp_lat counts edges from the start sample to done visible.
  task automatic run(input bit b, input logic [31:0] idd, input logic [31:0] tsd,
                     input int sid, input int sts, input bit stk, input bit poke,
                     input int nreads, input res_t e, input int exp_lat);
    int lat;
    sel = b; id_data = idd; ts_data = tsd;
    stall_id_cfg = sid; stall_ts_cfg = sts; stuck = stk;
    for (int i = 0; i < nreads; i++) addr_q.push_back(i[0]);
    res_q.push_back(e);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = 1;
    chk("busy_on", 32'(m_busy), 32'd1);
    chk("done_clr", 32'(m_done), 32'd0);
    while (!m_done && lat < 400) begin
      @(posedge clock); #1;
      lat++;
      start = poke && (lat == 2 || lat == 4);
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    @(negedge clock); #1;
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("read_off", 32'(m_read), 32'd0);
    stuck = 1'b0;
    res_q.delete(); addr_q.delete();
    repeat (2) @(posedge clock);
    #1 chk("done_held", 32'(m_done), 32'd1);
  endtask

  initial begin
    res_t ok_all, id_bad, ts_bad, to_id, to_ts, b_ok;
    ok_all = '{1'b1, 1'b1, 1'b0, 32'd0, TS, 0};
    id_bad = '{1'b0, 1'b1, 1'b0, 32'd5, TS, 0};
    ts_bad = '{1'b1, 1'b0, 1'b0, 32'd0, TS + 32'd1, 3};
    to_id  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 255};
    to_ts  = '{1'b0, 1'b0, 1'b1, 32'd7, 32'd0, 255};
    b_ok   = '{1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 0};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_read", 32'(a_read), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_id_value", a_id_value, 32'd0);
    chk("rst_ts_ok", 32'(b_ts_ok), 32'd0);
    reset = 1'b0;

    run(1'b0, 32'd0, TS, 0, 0, 1'b0, 1'b0, 2, ok_all, 3);
    run(1'b0, 32'd5, TS, 0, 0, 1'b0, 1'b0, 2, id_bad, 3);
    ok_all.stalls = 10;
    run(1'b0, 32'd0, TS, 10, 0, 1'b0, 1'b0, 2, ok_all, 13);
    run(1'b0, 32'd0, TS + 32'd1, 0, 3, 1'b0, 1'b0, 2, ts_bad, 6);
    run(1'b0, 32'd0, TS, 0, 0, 1'b1, 1'b0, 0, to_id, 256);
    run(1'b0, 32'd7, TS, 0, 1000, 1'b0, 1'b0, 1, to_ts, 257);

    run(1'b1, 32'd0, TS, 0, 0, 1'b0, 1'b0, 1, b_ok, 2);
    b_ok.stalls = 5;
    run(1'b1, 32'd0, TS, 5, 0, 1'b0, 1'b1, 1, b_ok, 7);

    // Reset while the timestamp read is stalled.
    sel = 1'b0; id_data = 32'd0; ts_data = TS;
    stall_id_cfg = 0; stall_ts_cfg = 1000;
    addr_q.push_back(1'b0);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #2 chk("pre_rst_read", 32'(m_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_read", 32'(a_read), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_done", 32'(a_done), 32'd0);
    chk("mid_rst_id_ok", 32'(a_id_ok), 32'd0);
    chk("mid_rst_addr", 32'(a_addr), 32'd0);
    chk("mid_rst_id_value", a_id_value, 32'd0);
    chk("mid_rst_ts_value", a_ts_value, 32'd0);
    addr_q.delete(); res_q.delete();
    @(posedge clock); #1 reset = 1'b0;
    ok_all.stalls = 0;
    run(1'b0, 32'd0, TS, 0, 0, 1'b0, 1'b0, 2, ok_all, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
